grid_sync_readout: RTL

- Grid-side counterpart of the per-column solver: initiator of the flag/start handshake and reader of every column's node_center output.
- Waits until all NCOLS columns raise flag, then snapshots the node_center bus for the current row.
- Converts each snapshotted node value to an 8-bit RRRGGGBB pixel and writes the pixels serially into the VGA frame buffer over a req/ack port.
- Then pulses start to release all columns for the next row update.

---
 rtl/grid_sync_readout_if.sv | 25 ++
 rtl/grid_sync_readout.sv | 135 +++++++++++++
 2 files changed

// File: rtl/grid_sync_readout_if.sv
// Frame-buffer write port used by grid_sync_readout.
// The port carries one pixel per req/ack transaction.
//   fb_wr_req  : write request. Held high until the frame buffer accepts it.
//   fb_addr    : pixel address.
//   fb_data    : RRRGGGBB pixel colour.
//   fb_wr_ack  : the frame buffer accepted the pending write.
// master = pixel writer (grid_sync_readout); slave = frame buffer.
interface grid_sync_readout_if #(
  parameter int FB_ADDR_W = 19
);
  logic                 fb_wr_req;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [7:0]           fb_data;
  logic                 fb_wr_ack;

  modport master (
    output fb_wr_req, fb_addr, fb_data,
    input  fb_wr_ack
  );

  modport slave (
    input  fb_wr_req, fb_addr, fb_data,
    output fb_wr_ack
  );
endinterface

// File: rtl/grid_sync_readout.sv
// Grid-side readout for the per-column solvers.
// The block waits until every column raises flag. It then snapshots all
// node_center values for the current row, writes one pixel per column into
// the frame buffer, and pulses start to release the columns for the next row.
// Ports:
//   clk, reset   : clock and synchronous active-high reset.
//   height       : index of the top row. row_idx wraps to 0 after it.
//   run          : while low, no new row cycle begins.
//   flag         : per-column value-ready flags.
//   node_bus     : node_center of column c in bits [32c+31:32c], format s4.27.
//   start        : one-cycle pulse that releases all columns.
//   fb           : frame-buffer write port (req/addr/data out, ack in).
//   row_idx      : row currently being read out.
//   frame_count  : number of completed full-grid passes (wraps at 16 bits).
//   busy         : high in every state except waiting for flags.
module grid_sync_readout #(
  parameter int NCOLS     = 8,
  parameter int ROW_BITS  = 7,
  parameter int SCREEN_W  = 640,
  parameter int X0        = 0,
  parameter int Y0        = 0,
  parameter int FB_ADDR_W = 19
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROW_BITS:0]      height,
  input  logic                   run,
  input  logic [NCOLS-1:0]       flag,
  input  logic [32*NCOLS-1:0]    node_bus,
  output logic                   start,
  grid_sync_readout_if.master    fb,
  output logic [ROW_BITS:0]      row_idx,
  output logic [15:0]            frame_count,
  output logic                   busy
);
  localparam int DATA_W = 32;
  localparam int COL_W  = (NCOLS > 1) ? $clog2(NCOLS) : 1;

  localparam logic [2:0] S_WAIT    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_DROP    = 3'd5;

  logic [2:0]              state;
  logic [COL_W-1:0]        col;
  logic signed [DATA_W-1:0] snap [NCOLS];
  logic [31:0]             addr_full;

  // s4.27 value to RRRGGGBB: negative is blue, >= 8.0 is red, otherwise the
  // integer part drives red up and blue down.
  function automatic logic [7:0] colour(input logic signed [DATA_W-1:0] v);
    logic [2:0] l;
    l = v[29:27];
    if (v[DATA_W-1])
      colour = 8'h03;
    else if (v[30])
      colour = 8'hE0;
    else
      colour = {l, 3'b000, ~l[2:1]};
  endfunction

  always_comb begin
    addr_full = (32'(Y0) + 32'(row_idx)) * 32'(SCREEN_W) + 32'(X0) + 32'(col);
  end

  assign busy = (state != S_WAIT);

  // The snapshot is the only place node_bus is sampled.
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE) begin
      for (int c = 0; c < NCOLS; c++) begin
        snap[c] <= node_bus[32*c +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_WAIT;
      start        <= 1'b0;
      fb.fb_wr_req <= 1'b0;
      fb.fb_addr   <= '0;
      fb.fb_data   <= '0;
      row_idx      <= '0;
      frame_count  <= '0;
      col          <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (run && (&flag)) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          col   <= '0;
          state <= S_REQ;
        end
        S_REQ: begin
          fb.fb_addr   <= addr_full[FB_ADDR_W-1:0];
          fb.fb_data   <= colour(snap[col]);
          fb.fb_wr_req <= 1'b1;
          state        <= S_ACK;
        end
        S_ACK: begin
          // req/addr/data hold until the frame buffer takes the pixel.
          if (fb.fb_wr_ack) begin
            fb.fb_wr_req <= 1'b0;
            if (col == COL_W'(NCOLS - 1)) begin
              start <= 1'b1;
              state <= S_RELEASE;
            end else begin
              col   <= col + 1'b1;
              state <= S_REQ;
            end
          end
        end
        S_RELEASE: begin
          start <= 1'b0;
          if (row_idx == height) begin
            row_idx     <= '0;
            frame_count <= frame_count + 16'd1;
          end else begin
            row_idx <= row_idx + 1'b1;
          end
          state <= S_DROP;
        end
        S_DROP: begin
          // Flags from the row just written must clear before they can count again.
          if (flag == '0) state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end
endmodule
